// File: rtl/ball_split_controller.sv
// ball_split_controller
//
// Tracks the ball tree of one level: the huge ball (0) splits into two big balls
// (1, 2), and each big ball splits into two medium balls (3..6). Ball i has
// children 2i+1 and 2i+2; medium balls have none. Collision flags from the
// detector are gathered into sticky registers during a frame and acted on once,
// at the startOfFrame pulse seen in IDLE. That frame's rope hit kills one ball
// and may spawn its children. That frame's player hit costs a life unless the
// player is still invulnerable.
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   levelStart           pulse: restart the level with only ball 0 alive
//   startOfFrame         pulse: once per video frame
//   col_rope[6:0]        rope/ball i collision, level-type
//   col_player[6:0]      player/ball i collision, level-type
//   ballAlive[6:0]       bit i high while ball i is in play
//   spawnValid           pulse: child spawnIdx of spawnParent became alive
//   spawnIdx, spawnParent
//   ropeHit              pulse: a rope hit was accepted
//   scoreAdd, scoreValue pulse plus points for the destroyed ball
//   playerHit            pulse: player lost a life
//   invulnerable         high while the invulnerability counter is nonzero
//   levelCleared         pulse: the last ball was destroyed
//   fsmState             current controller state, for observation only
//
// Every output is registered, so an event committed at cycle T appears at T+1.
module ball_split_controller #(
    parameter int          INVULN_FRAMES = 60,
    parameter logic [7:0]  SCORE_HUGE    = 8'd10,
    parameter logic [7:0]  SCORE_BIG     = 8'd20,
    parameter logic [7:0]  SCORE_MEDIUM  = 8'd40
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       levelStart,
    input  logic       startOfFrame,
    input  logic [6:0] col_rope,
    input  logic [6:0] col_player,
    output logic [6:0] ballAlive,
    output logic       spawnValid,
    output logic [2:0] spawnIdx,
    output logic [2:0] spawnParent,
    output logic       ropeHit,
    output logic       scoreAdd,
    output logic [7:0] scoreValue,
    output logic       playerHit,
    output logic       invulnerable,
    output logic       levelCleared,
    output logic [2:0] fsmState
);

    localparam int CW = $clog2(INVULN_FRAMES + 1);

    // CLEARED lasts one cycle to raise levelCleared, then DONE holds until levelStart.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPLIT_L = 3'd1,
        SPLIT_R = 3'd2,
        CLEARED = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state, stateNext;
    logic [6:0]    ropeSticky, ropeStickyNext;
    logic [6:0]    plyrSticky, plyrStickyNext;
    logic [CW-1:0] invCnt, invCntNext;
    logic [1:0]    hitIdx, hitIdxNext;   // only balls 0..2 split, so two bits suffice

    logic [6:0] aliveNext;
    logic       spawnValidNext, ropeHitNext, scoreAddNext, playerHitNext, levelClearedNext;
    logic [2:0] spawnIdxNext, spawnParentNext;
    logic [7:0] scoreValueNext;

    logic [6:0] ropeSnap, plyrSnap, aliveAfterHit;
    logic [2:0] winIdx, childL, childR;

    assign fsmState     = state;
    assign invulnerable = (invCnt != '0);

    always_comb begin
        // Snapshot that a commit would use this cycle; flags on dead balls never count.
        ropeSnap = ropeSticky | (col_rope & ballAlive);
        plyrSnap = plyrSticky | (col_player & ballAlive);

        // Lowest index wins the rope arbitration.
        winIdx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (ropeSnap[i]) winIdx = 3'(i);
        end
        aliveAfterHit = ballAlive & ~(7'b0000001 << winIdx);
        childL = {hitIdx, 1'b0} + 3'd1;
        childR = {hitIdx, 1'b0} + 3'd2;

        stateNext        = state;
        aliveNext        = ballAlive;
        ropeStickyNext   = ropeSnap;
        plyrStickyNext   = plyrSnap;
        invCntNext       = invCnt;
        hitIdxNext       = hitIdx;
        spawnValidNext   = 1'b0;
        ropeHitNext      = 1'b0;
        scoreAddNext     = 1'b0;
        playerHitNext    = 1'b0;
        levelClearedNext = 1'b0;
        spawnIdxNext     = spawnIdx;
        spawnParentNext  = spawnParent;
        scoreValueNext   = scoreValue;

        // The counter ticks on every frame, whatever the state; a fresh hit below overrides it.
        if (startOfFrame && invCnt != '0) invCntNext = invCnt - CW'(1);

        unique case (state)
            IDLE: begin
                if (startOfFrame) begin
                    ropeStickyNext = '0;
                    plyrStickyNext = '0;
                    if (ropeSnap != '0) begin
                        ropeHitNext  = 1'b1;
                        scoreAddNext = 1'b1;
                        if (winIdx == 3'd0)      scoreValueNext = SCORE_HUGE;
                        else if (winIdx < 3'd3)  scoreValueNext = SCORE_BIG;
                        else                     scoreValueNext = SCORE_MEDIUM;
                        aliveNext = aliveAfterHit;
                        if (winIdx < 3'd3) begin
                            hitIdxNext = winIdx[1:0];
                            stateNext  = SPLIT_L;
                        end else if (aliveAfterHit == '0) begin
                            stateNext = CLEARED;
                        end
                    end
                    // Judged against the alive mask from before the rope hit.
                    if (plyrSnap != '0 && invCnt == '0) begin
                        playerHitNext = 1'b1;
                        invCntNext    = CW'(INVULN_FRAMES);
                    end
                end
            end
            SPLIT_L: begin
                spawnValidNext    = 1'b1;
                spawnIdxNext      = childL;
                spawnParentNext   = {1'b0, hitIdx};
                aliveNext[childL] = 1'b1;
                stateNext         = SPLIT_R;
            end
            SPLIT_R: begin
                spawnValidNext    = 1'b1;
                spawnIdxNext      = childR;
                spawnParentNext   = {1'b0, hitIdx};
                aliveNext[childR] = 1'b1;
                stateNext         = IDLE;
            end
            CLEARED: begin
                levelClearedNext = 1'b1;
                stateNext        = DONE;
            end
            DONE: begin
                stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase

        // A level restart overrides everything that happened above.
        if (levelStart) begin
            stateNext        = IDLE;
            aliveNext        = 7'b0000001;
            ropeStickyNext   = '0;
            plyrStickyNext   = '0;
            invCntNext       = '0;
            spawnValidNext   = 1'b0;
            ropeHitNext      = 1'b0;
            scoreAddNext     = 1'b0;
            playerHitNext    = 1'b0;
            levelClearedNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            ballAlive    <= '0;
            ropeSticky   <= '0;
            plyrSticky   <= '0;
            invCnt       <= '0;
            hitIdx       <= '0;
            spawnValid   <= 1'b0;
            spawnIdx     <= '0;
            spawnParent  <= '0;
            ropeHit      <= 1'b0;
            scoreAdd     <= 1'b0;
            scoreValue   <= '0;
            playerHit    <= 1'b0;
            levelCleared <= 1'b0;
        end else begin
            state        <= stateNext;
            ballAlive    <= aliveNext;
            ropeSticky   <= ropeStickyNext;
            plyrSticky   <= plyrStickyNext;
            invCnt       <= invCntNext;
            hitIdx       <= hitIdxNext;
            spawnValid   <= spawnValidNext;
            spawnIdx     <= spawnIdxNext;
            spawnParent  <= spawnParentNext;
            ropeHit      <= ropeHitNext;
            scoreAdd     <= scoreAddNext;
            scoreValue   <= scoreValueNext;
            playerHit    <= playerHitNext;
            levelCleared <= levelClearedNext;
        end
    end

endmodule
